// File: rtl/lc3_pkg.sv
// lc3_pkg: shared LC-3 datapath definitions.
//  - REG_ADDR_W / DATA_W : register-file address and data widths
//  - CC_N / CC_Z / CC_P  : one-hot {N,Z,P} condition-code encodings
//  - CC_RESET            : condition code held after reset (Z)
package lc3_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 16;

  typedef logic [2:0] cc_t;

  localparam cc_t CC_N     = 3'b100;
  localparam cc_t CC_Z     = 3'b010;
  localparam cc_t CC_P     = 3'b001;
  localparam cc_t CC_RESET = CC_Z;

endpackage

// File: rtl/lc3_cc_logic.sv
// lc3_cc_logic: combinational encode of a two's-complement value to the
// one-hot {N,Z,P} condition code. Also used by the branch unit.
// Ports:
//  value  in   W   value to classify
//  cc     out  3   CC_N if negative, CC_Z if zero, CC_P otherwise
module lc3_cc_logic
  import lc3_pkg::*;
#(
  parameter int W = lc3_pkg::DATA_W
) (
  input  logic [W-1:0] value,
  output cc_t          cc
);

  always_comb begin
    cc = CC_P;
    if (value[W-1])       cc = CC_N;
    else if (value == '0) cc = CC_Z;
  end

endmodule

// File: rtl/lc3_reg_file.sv
// lc3_reg_file: LC-3 R0-R7 register file with a registered write-back stage
// and the NZP condition-code register.
//  Writes are captured into a pending stage on one edge and committed to the
//  array on the next, so back-to-back writes overlap capture and commit.
//  Optional feature macro: LC3_RF_BYPASS_EN
//   defined   -> reads forward a matching pending write, stall tied 0
//   undefined -> reads see the array only, stall flags a pending-write hazard
// Ports:
//  clk     in   1         rising-edge clock
//  rst_n   in   1         async active-low reset
//  ldReg   in   1         write request (busIn -> R[drSel])
//  drSel   in   AW        destination register
//  busIn   in   DATA_W    write-back data / NZP source
//  ldCC    in   1         update NZP from busIn
//  sr1Sel  in   AW        SR1 read address
//  sr2Sel  in   AW        SR2 read address
//  Ra      out  DATA_W    SR1 read data (combinational)
//  Rb      out  DATA_W    SR2 read data (combinational)
//  nzp     out  3         condition codes {N,Z,P} (registered)
//  stall   out  1         read hazard against the pending write
module lc3_reg_file
  import lc3_pkg::*;
#(
  parameter  int DATA_W   = lc3_pkg::DATA_W,
  parameter  int NUM_REGS = 8,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ldReg,
  input  logic [AW-1:0]     drSel,
  input  logic [DATA_W-1:0] busIn,
  input  logic              ldCC,
  input  logic [AW-1:0]     sr1Sel,
  input  logic [AW-1:0]     sr2Sel,
  output logic [DATA_W-1:0] Ra,
  output logic [DATA_W-1:0] Rb,
  output logic [2:0]        nzp,
  output logic              stall
);

  logic [NUM_REGS-1:0][DATA_W-1:0] gpr;

  logic              pend_valid;
  logic [AW-1:0]     pend_dr;
  logic [DATA_W-1:0] pend_data;

  cc_t cc_next;

  // Pending stage: one write in flight between capture and commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_dr    <= '0;
      pend_data  <= '0;
    end else begin
      pend_valid <= ldReg;
      pend_dr    <= drSel;
      pend_data  <= busIn;
    end
  end

  // One flop bank per register; each commits only its own pending write.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        gpr[r] <= '0;
      else if (pend_valid && pend_dr == AW'(r))
        gpr[r] <= pend_data;
    end
  end

  // NZP follows busIn directly, not the pending stage.
  lc3_cc_logic #(.W(DATA_W)) u_cc (
    .value (busIn),
    .cc    (cc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    nzp <= CC_RESET;
    else if (ldCC) nzp <= cc_next;
  end

`ifdef LC3_RF_BYPASS_EN
  assign Ra    = (pend_valid && pend_dr == sr1Sel) ? pend_data : gpr[sr1Sel];
  assign Rb    = (pend_valid && pend_dr == sr2Sel) ? pend_data : gpr[sr2Sel];
  assign stall = 1'b0;
`else
  assign Ra    = gpr[sr1Sel];
  assign Rb    = gpr[sr2Sel];
  // Array is one edge behind the pending write; the controller must hold.
  assign stall = pend_valid && (pend_dr == sr1Sel || pend_dr == sr2Sel);
`endif

endmodule

// File: tb/tb_lc3_reg_file.sv
module tb_lc3_reg_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ldReg, ldCC;
  logic [2:0]  drSel, sr1Sel, sr2Sel;
  logic [15:0] busIn;
  logic [15:0] Ra, Rb;
  logic [2:0]  nzp;
  logic        stall;

`ifdef LC3_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  lc3_reg_file dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ldReg  (ldReg),
    .drSel  (drSel),
    .busIn  (busIn),
    .ldCC   (ldCC),
    .sr1Sel (sr1Sel),
    .sr2Sel (sr2Sel),
    .Ra     (Ra),
    .Rb     (Rb),
    .nzp    (nzp),
    .stall  (stall)
  );

  always #5 clk = ~clk;

  // Reference model: history of writes since reset, each tagged with the
  // edge that sampled it. A write sampled at edge E is architecturally in the
  // array once a later edge has occurred; the one sampled at the latest edge
  // is the in-flight (pending) write.
  typedef struct {
    int          edge_n;
    int          dr;
    logic [15:0] data;
  } wr_t;

  wr_t         hist[$];
  int          cur_edge = 0;
  logic [2:0]  m_nzp    = 3'b010;
  int          total    = 0;
  int          passed   = 0;

  function automatic logic [15:0] arr_val(int r);
    logic [15:0] v = 16'h0;
    foreach (hist[i])
      if (hist[i].edge_n < cur_edge && hist[i].dr == r) v = hist[i].data;
    return v;
  endfunction

  function automatic int pend_idx();
    if (hist.size() > 0 && hist[hist.size()-1].edge_n == cur_edge)
      return hist.size() - 1;
    return -1;
  endfunction

  function automatic logic [15:0] exp_read(int r);
    int p = pend_idx();
    if (BYP && p >= 0 && hist[p].dr == r) return hist[p].data;
    return arr_val(r);
  endfunction

  function automatic logic exp_stall();
    int p = pend_idx();
    if (BYP || p < 0) return 1'b0;
    return (hist[p].dr == int'(sr1Sel)) || (hist[p].dr == int'(sr2Sel));
  endfunction

  function automatic logic [2:0] cc_of(logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'h0)     return 3'b010;
    return 3'b001;
  endfunction

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all(string tag);
    check({tag, ".Ra"},    Ra,              exp_read(int'(sr1Sel)));
    check({tag, ".Rb"},    Rb,              exp_read(int'(sr2Sel)));
    check({tag, ".nzp"},   {13'h0, nzp},    {13'h0, m_nzp});
    check({tag, ".stall"}, {15'h0, stall},  {15'h0, exp_stall()});
  endtask

  // Advance one clock; model samples the same inputs the DUT does.
  task automatic clk_edge();
    @(posedge clk);
    cur_edge++;
    if (ldReg) hist.push_back('{cur_edge, int'(drSel), busIn});
    if (ldCC)  m_nzp = cc_of(busIn);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    hist.delete();
    m_nzp = 3'b010;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; ldReg = 1'b0; ldCC = 1'b0;
    drSel = 3'd0; sr1Sel = 3'd0; sr2Sel = 3'd0; busIn = 16'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1. reset state
    for (int r = 0; r < 8; r++) begin
      sr1Sel = 3'(r); sr2Sel = 3'(7 - r);
      #1;
      check("rst.Ra", Ra, 16'h0);
      check_all("rst");
    end
    check("rst.nzp", {13'h0, nzp}, 16'h0002);
    check("rst.stall", {15'h0, stall}, 16'h0);

    // 2. write then read, inside and after the pending window
    ldReg = 1'b1; drSel = 3'd3; busIn = 16'h1234; sr1Sel = 3'd3; sr2Sel = 3'd0;
    clk_edge();
    ldReg = 1'b0; busIn = 16'h0;
    #1;
    check("t2.pend.Ra", Ra, BYP ? 16'h1234 : 16'h0000);
    check("t2.pend.stall", {15'h0, stall}, BYP ? 16'h0 : 16'h1);
    check_all("t2.pend");
    clk_edge();
    #1;
    check("t2.commit.Ra", Ra, 16'h1234);
    check_all("t2.commit");

    // 3. back-to-back writes
    ldReg = 1'b1; drSel = 3'd1; busIn = 16'h0005;
    clk_edge();
    drSel = 3'd2; busIn = 16'hFFFB;
    clk_edge();
    ldReg = 1'b0; busIn = 16'h0;
    clk_edge();
    sr1Sel = 3'd1; sr2Sel = 3'd2;
    #1;
    check("t3.Ra", Ra, 16'h0005);
    check("t3.Rb", Rb, 16'hFFFB);
    check_all("t3");

    // 4. NZP encoding
    ldCC = 1'b1; busIn = 16'h8000; clk_edge(); #1;
    check("t4.neg", {13'h0, nzp}, 16'h0004);
    busIn = 16'h0000; clk_edge(); #1;
    check("t4.zero", {13'h0, nzp}, 16'h0002);
    busIn = 16'h7FFF; clk_edge(); #1;
    check("t4.pos", {13'h0, nzp}, 16'h0001);
    ldCC = 1'b0; busIn = 16'h0000; clk_edge(); #1;
    check("t4.hold", {13'h0, nzp}, 16'h0001);
    check_all("t4");

    // 5. reset with a write in flight
    ldReg = 1'b1; drSel = 3'd7; busIn = 16'hBEEF;
    clk_edge();
    ldReg = 1'b0; busIn = 16'h0;
    pulse_reset();
    sr1Sel = 3'd7; sr2Sel = 3'd0;
    #1;
    check("t5.Ra", Ra, 16'h0);
    check("t5.stall", {15'h0, stall}, 16'h0);
    check_all("t5");
    clk_edge();
    #1;
    check("t5.after.Ra", Ra, 16'h0);
    check("t5.nzp", {13'h0, nzp}, 16'h0002);

    // 6. same-address read on both ports
    ldReg = 1'b1; drSel = 3'd5; busIn = 16'h00AA;
    clk_edge();
    ldReg = 1'b0; busIn = 16'h0;
    clk_edge();
    sr1Sel = 3'd5; sr2Sel = 3'd5;
    #1;
    check("t6.Ra", Ra, 16'h00AA);
    check("t6.Rb", Rb, 16'h00AA);
    check_all("t6");

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      ldReg  = 1'($urandom_range(0, 1));
      ldCC   = 1'($urandom_range(0, 1));
      drSel  = 3'($urandom_range(0, 7));
      sr1Sel = 3'($urandom_range(0, 7));
      sr2Sel = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       busIn = 16'h0000;
        1:       busIn = 16'h8000 | 16'($urandom);
        default: busIn = 16'($urandom);
      endcase
      #1;
      check_all("rnd");
      clk_edge();
    end
    ldReg = 1'b0; ldCC = 1'b0;
    for (int r = 0; r < 8; r++) begin
      clk_edge();
      sr1Sel = 3'(r); sr2Sel = 3'(7 - r);
      #1;
      check_all("final");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
